ext_ao_bus_arbiter: RTL

Round-robin arbiter that shares the single external always-on peripheral (AO peripheral bus) reg-bus master port among several external SPC requesters, e.g. im2col_spc and later accelerators. It sits in the FPGA/ASIC top wrapper between the SPC `reg_req_t`/`reg_rsp_t` master ports and the x_heep_system `ext_ao_peripheral_req_i[0]`/`ext_ao_peripheral_resp_o[0]` pair. It holds the grant for the full reg-bus transaction and recovers from a hung slave with a timeout error response.

---
 rtl/ext_ao_bus_arbiter.sv | 179 +++++++++++++++++
 1 files changed

// File: rtl/ext_ao_bus_arbiter.sv
// ---------------------------------------------------------------------------
// ext_ao_bus_arbiter
//
// Shares the single external always-on peripheral bus master port among
// NUM_REQ reg-bus requesters with round-robin priority. The grant is held for
// the whole reg-bus transaction; a slave that never answers is cut off after
// TIMEOUT_CYCLES waited cycles with an error response to the owner.
//
// Ports
//   clk_i          single clock
//   rst_i          asynchronous, active-high reset
//   req_i          requester requests (valid, write, addr, wdata, wstrb)
//   rsp_o          requester responses (ready, rdata, error)
//   aopb_req_o     request forwarded to the AO peripheral bus
//   aopb_rsp_i     response from the AO peripheral bus
//   grant_o        one-hot current owner, zero while idle
//   busy_o         a transaction is granted
//   timeout_o      one-cycle pulse, registered, in the cycle after a timeout
//                  error response
//   timeout_idx_o  owner index of the most recent timeout
// ---------------------------------------------------------------------------
package ext_ao_bus_pkg;
    typedef struct packed {
        logic        valid;
        logic        write;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
    } reg_req_t;

    typedef struct packed {
        logic        ready;
        logic [31:0] rdata;
        logic        error;
    } reg_rsp_t;
endpackage

module ext_ao_bus_arbiter
    import ext_ao_bus_pkg::*;
#(
    parameter int unsigned NUM_REQ        = 4,
    parameter int unsigned TIMEOUT_CYCLES = 255,
    parameter logic [31:0] ERR_RDATA      = 32'hBADC_AB1E,
    localparam int unsigned IW            = $clog2(NUM_REQ)
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  reg_req_t        req_i [NUM_REQ],
    output reg_rsp_t        rsp_o [NUM_REQ],
    output reg_req_t        aopb_req_o,
    input  reg_rsp_t        aopb_rsp_i,
    output logic [NUM_REQ-1:0] grant_o,
    output logic            busy_o,
    output logic            timeout_o,
    output logic [IW-1:0]   timeout_idx_o
);

    // A zero TIMEOUT_CYCLES disables the timeout; keep the counter 1 bit wide then.
    localparam int unsigned TW     = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic        TMO_EN = (TIMEOUT_CYCLES != 0);

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    state_t          state_q, state_d;
    logic [IW-1:0]   owner_q, owner_d;
    logic [IW-1:0]   last_q, last_d;
    logic [TW-1:0]   tmo_cnt_q, tmo_cnt_d;
    logic            timeout_q, timeout_d;
    logic [IW-1:0]   timeout_idx_q, timeout_idx_d;

    logic            any_valid_s;
    logic [IW-1:0]   rr_sel_s;
    logic [IW-1:0]   cand_s;
    reg_req_t        own_req_s;
    logic            tmo_hit_s;

    // Round-robin pick: first valid requester scanning last_q+1, last_q+2, ... (wrapping).
    always_comb begin
        any_valid_s = 1'b0;
        rr_sel_s    = '0;
        cand_s      = '0;
        for (int i = 1; i <= int'(NUM_REQ); i++) begin
            cand_s = IW'((int'(last_q) + i) % int'(NUM_REQ));
            if (!any_valid_s && req_i[cand_s].valid) begin
                any_valid_s = 1'b1;
                rr_sel_s    = cand_s;
            end else begin
                any_valid_s = any_valid_s;
            end
        end
    end

    assign own_req_s = req_i[owner_q];
    assign tmo_hit_s = TMO_EN && (tmo_cnt_q == TW'(TIMEOUT_CYCLES));

    // Next-state and forwarding mux; only the owner's response path is ever opened.
    always_comb begin
        state_d       = state_q;
        owner_d       = owner_q;
        last_d        = last_q;
        tmo_cnt_d     = tmo_cnt_q;
        timeout_d     = 1'b0;
        timeout_idx_d = timeout_idx_q;
        aopb_req_o    = '0;
        for (int k = 0; k < int'(NUM_REQ); k++) begin
            rsp_o[k] = '0;
        end

        case (state_q)
            IDLE: begin
                tmo_cnt_d = '0;
                if (any_valid_s) begin
                    owner_d = rr_sel_s;
                    state_d = GRANT;
                end else begin
                    state_d = IDLE;
                end
            end
            GRANT: begin
                aopb_req_o = own_req_s;
                if (!own_req_s.valid) begin
                    // Abort: a ready seen in this cycle is ignored, no response returned.
                    last_d  = owner_q;
                    state_d = IDLE;
                end else if (aopb_rsp_i.ready) begin
                    // Completion wins over a timeout falling in the same cycle.
                    rsp_o[owner_q] = aopb_rsp_i;
                    last_d         = owner_q;
                    state_d        = IDLE;
                end else if (tmo_hit_s) begin
                    aopb_req_o.valid = 1'b0;
                    rsp_o[owner_q]   = '{ready: 1'b1, rdata: ERR_RDATA, error: 1'b1};
                    timeout_d        = 1'b1;
                    timeout_idx_d    = owner_q;
                    last_d           = owner_q;
                    state_d          = IDLE;
                end else begin
                    rsp_o[owner_q] = aopb_rsp_i;
                    if (tmo_cnt_q != {TW{1'b1}}) begin
                        tmo_cnt_d = tmo_cnt_q + TW'(1);
                    end else begin
                        tmo_cnt_d = tmo_cnt_q;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State registers; last_q resets to the top index so requester 0 goes first.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q       <= IDLE;
            owner_q       <= '0;
            last_q        <= IW'(NUM_REQ - 1);
            tmo_cnt_q     <= '0;
            timeout_q     <= 1'b0;
            timeout_idx_q <= '0;
        end else begin
            state_q       <= state_d;
            owner_q       <= owner_d;
            last_q        <= last_d;
            tmo_cnt_q     <= tmo_cnt_d;
            timeout_q     <= timeout_d;
            timeout_idx_q <= timeout_idx_d;
        end
    end

    assign busy_o        = (state_q == GRANT);
    assign grant_o       = busy_o ? (NUM_REQ'(1) << owner_q) : '0;
    assign timeout_o     = timeout_q;
    assign timeout_idx_o = timeout_idx_q;

endmodule
